// File: rtl/triangle_fifo_arbiter.sv
// triangle_fifo_arbiter
// Shares one triangle_fifo write port between two vertex producers. Each grant
// covers a whole triangle (BEATS vertex+material beats written back to back,
// stalls allowed). FIFO occupancy is tracked with credits: BEATS entries are
// reserved at grant time and one entry is returned per FIFO pop. A grant is
// issued only when BEATS free entries are guaranteed.
//
// Optional feature: define TRI_ARB_STATS_EN to get per-producer completed
// triangle counters on tri_count_out. Without it tri_count_out is tied to 0.

module triangle_fifo_arbiter #(
    parameter int DEPTH = 1024,
    parameter int BEATS = 3,
    parameter int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [1:0]            req_valid_in,
    output logic [1:0]            req_ready_out,
    input  logic [1:0][3:0][31:0] req_vertex_in,
    input  logic [1:0][11:0]      req_material_in,
    output logic                  vertex_valid_out,
    output logic [3:0][31:0]      vertex_out,
    output logic                  material_valid_out,
    output logic [11:0]           material_out,
    input  logic                  pop_in,
    output logic [OCC_W-1:0]      occupancy_out,
    output logic [1:0]            grant_out,
    output logic                  underflow_out,
    output logic [1:0][15:0]      tri_count_out
);

    localparam int                BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [OCC_W-1:0]  OCC_LIMIT = OCC_W'(DEPTH - BEATS);
    localparam logic [OCC_W-1:0]  OCC_BEATS = OCC_W'(BEATS);
    localparam logic [OCC_W-1:0]  OCC_ONE   = OCC_W'(1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t             state_q;
    logic [1:0]         grant_q;
    logic               prio_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [OCC_W-1:0]   occ_q;
    logic               underflow_q;
    logic               wr_valid_q;
    logic [3:0][31:0]   vertex_q;
    logic [11:0]        material_q;

    logic               owner;
    logic               winner;
    logic               accept;
    logic               last_accept;
    logic               grant_fire;
    logic [OCC_W-1:0]   occ_next;
    logic               underflow_hit;

    // Ready depends only on who owns the port, never on the requests.
    assign req_ready_out = (state_q == ST_GRANT) ? grant_q : 2'b00;

    // Index of the current owner; only meaningful while granted.
    assign owner       = grant_q[1];
    assign accept      = |(req_valid_in & req_ready_out);
    assign last_accept = accept && (beat_q == LAST_BEAT);

    // Round-robin: the pointed-to producer wins if it asks, else the other.
    assign winner     = req_valid_in[prio_q] ? prio_q : ~prio_q;
    assign grant_fire = (state_q == ST_IDLE) && (|req_valid_in) && (occ_q <= OCC_LIMIT);

    // Next occupancy: reserve on grant, release on pop, saturate at zero on underflow.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        occ_next      = occ_q;
        underflow_hit = 1'b0;
        if (grant_fire) begin
            occ_next = pop_in ? (occ_q + OCC_BEATS - OCC_ONE) : (occ_q + OCC_BEATS);
        end else if (pop_in) begin
            if (occ_q != '0) begin
                occ_next = occ_q - OCC_ONE;
            end else begin
                underflow_hit = 1'b1;
            end
        end
    end

    // Credit counter and sticky underflow flag.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses <= so every register updates from pre-edge values.
        if (rst_in) begin
            occ_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            occ_q <= occ_next;
            if (underflow_hit) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Grant FSM: pick an owner in IDLE, hold it until its last beat is accepted.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            prio_q  <= 1'b0;
            beat_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_fire) begin
                        state_q <= ST_GRANT;
                        grant_q <= winner ? 2'b10 : 2'b01;
                        beat_q  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (accept) begin
                        if (last_accept) begin
                            state_q <= ST_IDLE;
                            grant_q <= 2'b00;
                            prio_q  <= ~owner;
                            beat_q  <= '0;
                        end else begin
                            beat_q <= beat_q + BEAT_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    // Output register: accepted beat goes to the FIFO one cycle later; data holds otherwise.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_valid_q <= 1'b0;
            vertex_q   <= '0;
            material_q <= '0;
        end else begin
            wr_valid_q <= accept;
            if (accept) begin
                vertex_q   <= req_vertex_in[owner];
                material_q <= req_material_in[owner];
            end
        end
    end

    assign vertex_valid_out   = wr_valid_q;
    assign material_valid_out = wr_valid_q;
    assign vertex_out         = vertex_q;
    assign material_out       = material_q;
    assign occupancy_out      = occ_q;
    assign grant_out          = grant_q;
    assign underflow_out      = underflow_q;

`ifdef TRI_ARB_STATS_EN
    logic [1:0][15:0] tri_cnt_q;

    // Completed-triangle counters, one per producer, wrapping at 16 bits.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tri_cnt_q <= '0;
        end else if (last_accept) begin
            tri_cnt_q[owner] <= tri_cnt_q[owner] + 16'd1;
        end
    end

    assign tri_count_out = tri_cnt_q;
`else
    assign tri_count_out = '0;
`endif

endmodule

// File: tb/tb_triangle_fifo_arbiter.sv
// Testbench for triangle_fifo_arbiter: directed scenarios plus a randomized
// phase, all compared every cycle against a transaction-level model
// (owner / beats-done / credit count as plain integers).

module tb_triangle_fifo_arbiter;

    localparam int DEPTH = 1024;
    localparam int BEATS = 3;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic [1:0]            req_valid_in;
    logic [1:0]            req_ready_out;
    logic [1:0][3:0][31:0] req_vertex_in;
    logic [1:0][11:0]      req_material_in;
    logic                  vertex_valid_out;
    logic [3:0][31:0]      vertex_out;
    logic                  material_valid_out;
    logic [11:0]           material_out;
    logic                  pop_in;
    logic [OCC_W-1:0]      occupancy_out;
    logic [1:0]            grant_out;
    logic                  underflow_out;
    logic [1:0][15:0]      tri_count_out;

    always #5 clk_in = ~clk_in;

    triangle_fifo_arbiter #(.DEPTH(DEPTH), .BEATS(BEATS), .OCC_W(OCC_W)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .req_valid_in       (req_valid_in),
        .req_ready_out      (req_ready_out),
        .req_vertex_in      (req_vertex_in),
        .req_material_in    (req_material_in),
        .vertex_valid_out   (vertex_valid_out),
        .vertex_out         (vertex_out),
        .material_valid_out (material_valid_out),
        .material_out       (material_out),
        .pop_in             (pop_in),
        .occupancy_out      (occupancy_out),
        .grant_out          (grant_out),
        .underflow_out      (underflow_out),
        .tri_count_out      (tri_count_out)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int           m_owner = -1;   // producer holding the port, -1 when idle
    int           m_beats = 0;    // beats of the current triangle already taken
    int           m_prio  = 0;
    int           m_occ   = 0;
    bit           m_under = 1'b0;
    bit           m_wv    = 1'b0;
    logic [127:0] m_vert  = '0;
    logic [11:0]  m_mat   = '0;
    int           m_cnt[2] = '{0, 0};
    bit           m_acc;
    bit           m_grant_now;

    always @(posedge clk_in) begin
        if (rst_in) begin
            m_owner = -1; m_beats = 0; m_prio = 0; m_occ = 0;
            m_under = 1'b0; m_wv = 1'b0; m_vert = '0; m_mat = '0;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else begin
            m_acc = 1'b0;
            if (m_owner >= 0) m_acc = req_valid_in[m_owner];
            m_grant_now = (m_owner < 0) && (req_valid_in != 2'b00) && (DEPTH - m_occ >= BEATS);
            m_wv = m_acc;
            if (m_acc) begin
                m_vert = req_vertex_in[m_owner];
                m_mat  = req_material_in[m_owner];
            end
            if (pop_in) begin
                if (m_grant_now)    m_occ = m_occ + BEATS - 1;
                else if (m_occ > 0) m_occ = m_occ - 1;
                else                m_under = 1'b1;
            end else if (m_grant_now) begin
                m_occ = m_occ + BEATS;
            end
            if (m_acc) begin
                m_beats++;
                if (m_beats == BEATS) begin
                    m_cnt[m_owner] = (m_cnt[m_owner] + 1) % 65536;
                    m_prio  = 1 - m_owner;
                    m_owner = -1;
                    m_beats = 0;
                end
            end else if (m_grant_now) begin
                m_owner = req_valid_in[m_prio] ? m_prio : 1 - m_prio;
            end
        end
    end

    // ---------------- compare process + DUT-side logs ----------------
    bit          check_en = 1'b0;
    logic [1:0]  exp_grant;
    logic [15:0] exp_cnt0, exp_cnt1;
    logic [1:0]  prev_grant = 2'b00;
    bit          dut_grants[$];
    logic [31:0] dut_words[$];

    always @(negedge clk_in) begin
        if (check_en) begin
            exp_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
`ifdef TRI_ARB_STATS_EN
            exp_cnt0 = 16'(m_cnt[0]);
            exp_cnt1 = 16'(m_cnt[1]);
`else
            exp_cnt0 = 16'd0;
            exp_cnt1 = 16'd0;
`endif
            check("grant", grant_out, exp_grant);
            check("ready", req_ready_out, exp_grant);
            check("vertex_valid", vertex_valid_out, m_wv);
            check("material_valid", material_valid_out, m_wv);
            check("vertex", vertex_out, m_vert);
            check("material", material_out, m_mat);
            check("occupancy", occupancy_out, 128'(m_occ));
            check("underflow", underflow_out, m_under);
            check("tri_count0", tri_count_out[0], exp_cnt0);
            check("tri_count1", tri_count_out[1], exp_cnt1);
        end
        if (grant_out != 2'b00 && prev_grant == 2'b00) dut_grants.push_back(grant_out[1]);
        prev_grant = grant_out;
        if (vertex_valid_out) dut_words.push_back(vertex_out[0]);
    end

    // ---------------- producer driver ----------------
    int remaining[2] = '{0, 0};
    bit hold[2]      = '{0, 0};
    int seq[2]       = '{0, 0};
    bit last_acc[2]  = '{0, 0};
    bit mix          = 1'b0;

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            req_valid_in[i]    = (remaining[i] > 0) && !hold[i];
            req_vertex_in[i]   = {~32'(seq[i]), 32'(seq[i] * 7), 32'(i), 32'((i << 16) | (seq[i] + 1))};
            req_material_in[i] = ((i == 0) ? 12'h0A5 : 12'h15A) ^ (mix ? 12'(seq[i]) : 12'h000);
            last_acc[i]        = req_valid_in[i] && req_ready_out[i];
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (last_acc[i]) begin
                remaining[i]--;
                seq[i]++;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        pop_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            remaining[i] = 0; hold[i] = 1'b0; seq[i] = 0; last_acc[i] = 1'b0;
        end
        drive();
        tick();
        tick();
        rst_in = 1'b0;
        drive();
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while ((remaining[0] > 0 || remaining[1] > 0 || grant_out != 2'b00) && n < max_cycles) begin
            tick();
            n++;
        end
        check("idle_within_budget", n < max_cycles, 1'b1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 1000000");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int mism;
        logic [3:0] order;

        rst_in = 1'b1;
        pop_in = 1'b0;
        drive();
        do_reset();
        check_en = 1'b1;

        // Reset state
        check("reset_grant", grant_out, 2'b00);
        check("reset_ready", req_ready_out, 2'b00);
        check("reset_occ", occupancy_out, 0);
        check("reset_underflow", underflow_out, 1'b0);
        check("reset_vvalid", vertex_valid_out, 1'b0);
        check("reset_vertex", vertex_out, 0);
        check("reset_tri_count", tri_count_out, 0);

        // Single producer: one triangle 0x1,0x2,0x3
        dut_words.delete(); dut_grants.delete();
        remaining[0] = 3;
        drive();
        tick();
        check("single_grant", grant_out, 2'b01);
        check("single_ready", req_ready_out, 2'b01);
        check("single_occ", occupancy_out, 3);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("single_wr_valid", vertex_valid_out, 1'b1);
            check("single_wr_vertex", vertex_out[0], k);
            check("single_wr_material", material_out, 12'h0A5);
            check("single_ready_window", req_ready_out, (k < 3) ? 2'b01 : 2'b00);
        end
        tick();
        check("single_wr_done", vertex_valid_out, 1'b0);
        check("single_occ_final", occupancy_out, 3);
        check("single_beats", dut_words.size(), 3);

        // Contention: both producers, two triangles each
        do_reset();
        dut_words.delete(); dut_grants.delete();
        remaining[0] = 6; remaining[1] = 6;
        drive();
        wait_idle(60);
        check("contention_grants", dut_grants.size(), 4);
        order = 4'hF;
        for (int k = 0; k < 4 && k < dut_grants.size(); k++) order[k] = dut_grants[k];
        check("contention_order", order, 4'b1010);
        check("contention_beats", dut_words.size(), 12);
        mism = 0;
        for (int k = 0; k < dut_words.size(); k++) begin
            if (dut_words[k][31:16] != 16'((k / 3) % 2)) mism++;
        end
        check("contention_interleave", mism, 0);
        check("contention_occ", occupancy_out, 12);

        // Stall: producer 1 owns, stalls 10 cycles after first beat
        do_reset();
        dut_words.delete(); dut_grants.delete();
        remaining[1] = 3;
        drive();
        n = 0;
        while (seq[1] < 1 && n < 20) begin
            tick();
            n++;
        end
        check("stall_first_beat_budget", n < 20, 1'b1);
        hold[1] = 1'b1;
        remaining[0] = 3;
        drive();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stall_grant_held", grant_out, 2'b10);
            check("stall_ready", req_ready_out, 2'b10);
        end
        hold[1] = 1'b0;
        drive();
        wait_idle(40);
        check("stall_grants", dut_grants.size(), 2);
        if (dut_grants.size() == 2) begin
            check("stall_first_owner", dut_grants[0], 1'b1);
            check("stall_second_owner", dut_grants[1], 1'b0);
        end
        check("stall_beats", dut_words.size(), 6);
        if (dut_words.size() >= 3) begin
            check("stall_word0", dut_words[0], 32'h0001_0001);
            check("stall_word1", dut_words[1], 32'h0001_0002);
            check("stall_word2", dut_words[2], 32'h0001_0003);
        end

        // Full boundary: preload 1022 via 341 grants and one pop
        do_reset();
        remaining[0] = 3 * 341 + 3;
        drive();
        n = 0;
        while (remaining[0] > 3 && n < 2000) begin
            tick();
            n++;
            pop_in = (n == 10);
        end
        pop_in = 1'b0;
        check("preload_budget", n < 2000, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        check("full_no_grant", grant_out, 2'b00);
        check("full_occ", occupancy_out, 1022);
        pop_in = 1'b1;
        tick();
        pop_in = 1'b0;
        check("full_pop_no_grant", grant_out, 2'b00);
        check("full_pop_occ", occupancy_out, 1021);
        tick();
        check("full_late_grant", grant_out, 2'b01);
        check("full_late_occ", occupancy_out, 1024);
        wait_idle(20);
        check("full_final_occ", occupancy_out, 1024);

        // Simultaneous grant and pop at occupancy 5
        do_reset();
        remaining[0] = 3;
        drive();
        wait_idle(20);
        pop_in = 1'b1;
        tick();
        pop_in = 1'b0;
        check("simul_occ2", occupancy_out, 2);
        remaining[0] = 3;
        drive();
        wait_idle(20);
        check("simul_occ5", occupancy_out, 5);
        remaining[0] = 3;
        pop_in = 1'b1;
        drive();
        tick();
        pop_in = 1'b0;
        check("simul_grant", grant_out, 2'b01);
        check("simul_occ7", occupancy_out, 7);
        wait_idle(20);

        // Underflow at occupancy 0
        do_reset();
        pop_in = 1'b1;
        tick();
        pop_in = 1'b0;
        check("underflow_set", underflow_out, 1'b1);
        check("underflow_occ", occupancy_out, 0);
        for (int k = 0; k < 3; k++) tick();
        check("underflow_sticky", underflow_out, 1'b1);
        do_reset();
        check("underflow_cleared", underflow_out, 1'b0);

        // Stats, then reset mid-triangle
        remaining[1] = 6;
        drive();
        wait_idle(40);
`ifdef TRI_ARB_STATS_EN
        check("stats_count1", tri_count_out[1], 16'd2);
`else
        check("stats_count1", tri_count_out[1], 16'd0);
`endif
        check("stats_count0", tri_count_out[0], 16'd0);
        remaining[0] = 3;
        drive();
        n = 0;
        while (seq[0] < 1 && n < 20) begin
            tick();
            n++;
        end
        check("midtri_budget", n < 20, 1'b1);
        check("midtri_grant_before", grant_out, 2'b01);
        rst_in = 1'b1;
        remaining[0] = 0;
        drive();
        tick();
        check("midrst_grant", grant_out, 2'b00);
        check("midrst_ready", req_ready_out, 2'b00);
        check("midrst_vvalid", vertex_valid_out, 1'b0);
        check("midrst_mvalid", material_valid_out, 1'b0);
        check("midrst_vertex", vertex_out, 0);
        check("midrst_material", material_out, 0);
        check("midrst_occ", occupancy_out, 0);
        check("midrst_underflow", underflow_out, 1'b0);
        check("midrst_tri_count", tri_count_out, 0);
        do_reset();

        // Randomized traffic with one reset in the middle
        mix = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            for (int i = 0; i < 2; i++) begin
                if (remaining[i] == 0 && $urandom_range(0, 7) == 0) remaining[i] = 3 * $urandom_range(1, 3);
                hold[i] = ($urandom_range(0, 3) == 0);
            end
            pop_in = ($urandom_range(0, 2) == 0);
            drive();
            tick();
        end
        pop_in = 1'b0;
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        drive();
        tick();

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/triangle_fifo_arbiter.md
Name: triangle_fifo_arbiter

Overview:
- Shares one triangle_fifo write port between two vertex producers, for example two vertex-shader lanes.
- Each producer grant covers a whole triangle: three vertex+material beats, written atomically and in order.
- Tracks FIFO occupancy with credits, because the FIFO has no overflow protection. A grant is issued only when 3 free entries are guaranteed.
- Sits between the producers and the triangle_fifo vertex/material write inputs. It observes the FIFO read handshake to return credits.

Parameters:
- DEPTH, 1024, FIFO entry count; must match triangle_fifo RAM_DEPTH.
- BEATS, 3, vertices per triangle.
- OCC_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- req_valid_in  input  [1:0]  producer i has a vertex beat
- req_ready_out  output  [1:0]  beat from producer i accepted this cycle when valid&ready
- req_vertex_in  input  [1:0][3:0][31:0]  vertex per producer
- req_material_in  input  [1:0][11:0]  material per producer
- vertex_valid_out  output  1  write strobe to FIFO vertex port
- vertex_out  output  [3:0][31:0]  vertex to FIFO
- material_valid_out  output  1  write strobe to FIFO material port; always equals vertex_valid_out
- material_out  output  [11:0]  material to FIFO
- pop_in  input  1  FIFO consumer handshake (valid_out && ready_in of FIFO)
- occupancy_out  output  OCC_W  reserved+written entries not yet popped
- grant_out  output  [1:0]  one-hot current owner, 0 when idle
- underflow_out  output  1  sticky: pop_in seen with occupancy 0
- tri_count_out  output  [1:0][15:0]  completed triangles per producer (optional feature)

Behaviour:
- Reset values: all outputs 0, state IDLE, priority pointer = producer 0, beat counter 0.
- States:
  - IDLE: pick a requester when any req_valid_in is set AND DEPTH - occupancy >= BEATS (occupancy sampled this cycle).
    - Round-robin: the requester at the priority pointer wins if valid, else the other.
    - Next cycle -> GRANT; grant_out becomes one-hot; occupancy += BEATS (reservation).
  - GRANT: req_ready_out[g] = 1 for owner g only; other ready = 0.
    - Each cycle req_valid_in[g] is high, the beat is accepted and the beat counter increments.
    - Owner may stall (valid low) indefinitely; the grant is held and the other producer is not served.
    - On acceptance of beat BEATS-1: -> IDLE next cycle, priority pointer = other producer, beat counter = 0.
- req_ready_out is combinational from state and grant only. It never depends on req_valid_in.
- Output register:
  - Accepted beat appears on vertex_out/material_out with vertex_valid_out = material_valid_out = 1 exactly 1 cycle after acceptance.
  - Otherwise the strobes are 0 and the data holds its last value.
- Minimum triangle period: 1 IDLE cycle + 3 beats = 4 cycles. Back-to-back triangles alternate producers when both request.
- Occupancy update per cycle: +BEATS on grant, -1 on pop_in; both in the same cycle nets +2.
  - pop_in with occupancy 0 and no simultaneous grant: occupancy stays 0 and underflow_out sets.
  - underflow_out clears only on reset.
- Full boundary:
  - occupancy = DEPTH-2 in IDLE: no grant, even if pop_in is high that cycle; the grant decision uses the pre-update value.
  - Grant occurs on the following cycle if space is then sufficient.
- Reset mid-triangle: the partial triangle is discarded and all state returns to reset values. The FIFO must be reset in the same cycle (system requirement; not checked by this block).

Optional Feature:
- Macro TRI_ARB_STATS_EN.
- When defined: tri_count_out[i] increments (16-bit, wraps 0xFFFF -> 0) on acceptance of the last beat of each triangle from producer i. Reset to 0.
- When undefined: tri_count_out tied to 0 and no counter registers are synthesized.

Test Plan:
- Single producer:
  - Stimulus: producer 0 valid continuously with vertices 0x1,0x2,0x3 and material 0x0A5.
  - Required: grant_out = 01 one cycle after valid; ready_out[0] high for 3 cycles; vertex_valid_out pulses 3 cycles carrying 0x1,0x2,0x3, each 1 cycle after acceptance; occupancy_out = 3.
- Contention:
  - Stimulus: both producers continuously valid for 4 triangles.
  - Required: grant order 0,1,0,1; 12 write beats total; never interleaved within a triangle; occupancy_out = 12.
- Stall:
  - Stimulus: producer 1 granted, drops valid after beat 1 for 10 cycles while producer 0 is valid.
  - Required: grant stays 10; ready_out[0] = 0 throughout; triangle completes when producer 1 resumes.
- Full:
  - Stimulus: preload to occupancy 1022 (DEPTH=1024) with no pops.
  - Required: no grant. A single pop_in gives occupancy 1021; grant issues next cycle; occupancy then 1024.
- Simultaneous grant and pop:
  - Stimulus: occupancy 5, grant cycle with pop_in = 1.
  - Required: occupancy 7. Separately, pop_in at occupancy 0 sets underflow_out and occupancy stays 0.
- Stats and reset:
  - With TRI_ARB_STATS_EN: after 2 triangles from producer 1, tri_count_out[1] = 2.
  - rst_in asserted mid-triangle: all outputs 0 the next cycle, including counts.
